// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  // Fetch FSM: S_REQ issues/awaits a fetch, S_FULL parks a fetched word
  // while ID stalls, S_DROP waits out an access abandoned by a redirect.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_FULL = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  // IF/ID pipeline register contents
  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  function automatic ifid_t make_bubble(input logic [31:0] nop);
    ifid_t b;
    b.pc_plus4 = 32'h0;
    b.instr    = nop;
    b.valid    = 1'b0;
    return b;
  endfunction

  localparam ifid_t IFID_BUBBLE = make_bubble(NOP_INSTR_DEF);

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load / flush-to-bubble / hold controls.
// Latency: 1 cycle from load_i or flush_i to q_o.
// Backpressure: holds its contents whenever neither load_i nor flush_i is set.
// Ports: clk_i, rst_i (sync, active-high), load_i, flush_i, data_i (ifid_t), q_o (ifid_t).
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  load_i,
  input  logic  flush_i,
  input  ifid_t data_i,
  output ifid_t q_o
);

  ifid_t q_q;
  ifid_t q_d;

  // Flush wins over load so a redirect always leaves a bubble behind.
  always_comb begin
    q_d = q_q;
    if (flush_i) begin
      q_d = make_bubble(NOP_INSTR);
    end else if (load_i) begin
      q_d = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= make_bubble(NOP_INSTR);
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC, request/ack imem port, one-entry fetch buffer, IF/ID register.
// Latency: fetched word lands in IF/ID on the edge that sees ack with adv set.
// Backpressure: a word acked during a stall is parked; no new request until it drains.
// Ports: clk_i, rst_i, pc_write_i, if_id_write_i, if_flush_i, branch_target_i,
//        imem_req_o/addr_o/ack_i/rdata_i, id_pc_plus4_o, id_instr_o, id_valid_o.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_write_i,
  input  logic        if_id_write_i,
  input  logic        if_flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] id_pc_plus4_o,
  output logic [31:0] id_instr_o,
  output logic        id_valid_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  fb_instr_q, fb_instr_d;

  logic         adv;
  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         id_load;
  logic         id_flush;
  ifid_t        id_data;
  ifid_t        id_q;

  assign adv      = pc_write_i & if_id_write_i;
  assign pc_plus4 = pc_q + 32'd4;                 // wraps modulo 2^32
  assign target   = branch_target_i & ~32'h3;     // force word alignment

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    fb_instr_d = fb_instr_q;
    id_load    = 1'b0;
    id_flush   = 1'b0;
    id_data    = '{pc_plus4: pc_plus4, instr: imem_rdata_i, valid: 1'b1};
    case (state_q)
      S_REQ: begin
        if (imem_ack_i) begin
          if (if_flush_i) begin
            pc_d     = target;
            id_flush = 1'b1;
          end else if (adv) begin
            id_load = 1'b1;
            pc_d    = pc_plus4;
          end else begin
            fb_instr_d = imem_rdata_i;
            state_d    = S_FULL;
          end
        end else if (if_flush_i) begin
          // The access to pc is still in flight; remember its address so
          // the port stays stable until memory acknowledges it.
          req_addr_d = pc_q;
          pc_d       = target;
          id_flush   = 1'b1;
          state_d    = S_DROP;
        end else if (adv) begin
          id_flush = 1'b1;
        end
      end
      S_FULL: begin
        if (if_flush_i) begin
          pc_d     = target;
          id_flush = 1'b1;
          state_d  = S_REQ;
        end else if (adv) begin
          id_load       = 1'b1;
          id_data.instr = fb_instr_q;
          pc_d          = pc_plus4;
          state_d       = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_ack_i) begin
          state_d = S_REQ;
        end
        if (if_flush_i) begin
          pc_d     = target;
          id_flush = 1'b1;
        end else if (adv) begin
          id_flush = 1'b1;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      fb_instr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      fb_instr_q <= fb_instr_d;
    end
  end

  assign imem_req_o  = (state_q != S_FULL);
  assign imem_addr_o = (state_q == S_DROP) ? req_addr_q : pc_q;

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (id_load),
    .flush_i (id_flush),
    .data_i  (id_data),
    .q_o     (id_q)
  );

  assign id_pc_plus4_o = id_q.pc_plus4;
  assign id_instr_o    = id_q.instr;
  assign id_valid_o    = id_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall buffer, redirects, wrap.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        pc_write_i;
  logic        if_id_write_i;
  logic        if_flush_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] id_pc_plus4_o;
  logic [31:0] id_instr_o;
  logic        id_valid_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .pc_write_i      (pc_write_i),
    .if_id_write_i   (if_id_write_i),
    .if_flush_i      (if_flush_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_rdata_i    (imem_rdata_i),
    .id_pc_plus4_o   (id_pc_plus4_o),
    .id_instr_o      (id_instr_o),
    .id_valid_o      (id_valid_o)
  );

  // Memory contents: a recognisable word per address, never equal to the NOP.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    pc_write_i = 1'b0; if_id_write_i = 1'b0; if_flush_i = 1'b0;
    branch_target_i = 32'h0; imem_ack_i = 1'b0; imem_rdata_i = 32'h0;
    step();
    step();
    chk("reset_req",   {31'h0, imem_req_o}, 32'h1);
    chk("reset_addr",  imem_addr_o, 32'h0);
    chk("reset_valid", {31'h0, id_valid_o}, 32'h0);
    chk("reset_instr", id_instr_o, 32'h0);
    chk("reset_pc4",   id_pc_plus4_o, 32'h0);
    rst_i = 1'b0;
  endtask

  task automatic test_zero_wait();
    pc_write_i = 1'b1; if_id_write_i = 1'b1; imem_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'(4 * i);
      chk("zw_addr", imem_addr_o, a);
      chk("zw_req", {31'h0, imem_req_o}, 32'h1);
      imem_rdata_i = mem_word(a);
      step();
      chk("zw_valid", {31'h0, id_valid_o}, 32'h1);
      chk("zw_pc4", id_pc_plus4_o, a + 32'd4);
      chk("zw_instr", id_instr_o, mem_word(a));
    end
  endtask

  task automatic test_stall_buffer();
    chk("st_addr", imem_addr_o, 32'h10);
    imem_ack_i = 1'b1; imem_rdata_i = mem_word(32'h10);
    pc_write_i = 1'b1; if_id_write_i = 1'b0;    // adv=0 with ack
    step();
    imem_ack_i = 1'b0; imem_rdata_i = 32'hDEAD_BEEF;
    pc_write_i = 1'b0; if_id_write_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("st_req_low", {31'h0, imem_req_o}, 32'h0);
      chk("st_hold_pc4", id_pc_plus4_o, 32'h10);
      chk("st_hold_instr", id_instr_o, mem_word(32'hC));
      step();
    end
    pc_write_i = 1'b1; if_id_write_i = 1'b1;
    step();
    chk("st_buf_instr", id_instr_o, mem_word(32'h10));
    chk("st_buf_pc4", id_pc_plus4_o, 32'h14);
    chk("st_buf_valid", {31'h0, id_valid_o}, 32'h1);
    chk("st_next_req", {31'h0, imem_req_o}, 32'h1);
    chk("st_next_addr", imem_addr_o, 32'h14);
  endtask

  task automatic test_flush_latency();
    imem_ack_i = 1'b0; pc_write_i = 1'b1; if_id_write_i = 1'b1;
    chk("fl_addr0", imem_addr_o, 32'h14);
    step();
    chk("fl_miss_valid", {31'h0, id_valid_o}, 32'h0);
    chk("fl_addr1", imem_addr_o, 32'h14);
    if_flush_i = 1'b1; branch_target_i = 32'h103;  // low bits must be dropped
    step();
    if_flush_i = 1'b0;
    chk("fl_drop_addr", imem_addr_o, 32'h14);
    chk("fl_drop_req", {31'h0, imem_req_o}, 32'h1);
    chk("fl_drop_valid", {31'h0, id_valid_o}, 32'h0);
    imem_ack_i = 1'b1; imem_rdata_i = mem_word(32'h14);
    step();
    chk("fl_discard_valid", {31'h0, id_valid_o}, 32'h0);
    chk("fl_target_addr", imem_addr_o, 32'h100);
    imem_rdata_i = mem_word(32'h100);
    step();
    chk("fl_tgt_valid", {31'h0, id_valid_o}, 32'h1);
    chk("fl_tgt_instr", id_instr_o, mem_word(32'h100));
    chk("fl_tgt_pc4", id_pc_plus4_o, 32'h104);
  endtask

  task automatic test_flush_with_ack();
    chk("fa_addr0", imem_addr_o, 32'h104);
    imem_ack_i = 1'b1; imem_rdata_i = mem_word(32'h104);
    if_flush_i = 1'b1; branch_target_i = 32'h100;
    step();
    if_flush_i = 1'b0;
    chk("fa_valid", {31'h0, id_valid_o}, 32'h0);
    chk("fa_instr", id_instr_o, 32'h0);
    chk("fa_addr", imem_addr_o, 32'h100);
    chk("fa_req", {31'h0, imem_req_o}, 32'h1);
  endtask

  task automatic test_wrap();
    imem_ack_i = 1'b1; if_flush_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
    step();
    if_flush_i = 1'b0;
    chk("wr_addr", imem_addr_o, 32'hFFFF_FFFC);
    imem_rdata_i = mem_word(32'hFFFF_FFFC);
    pc_write_i = 1'b1; if_id_write_i = 1'b1;
    step();
    chk("wr_pc4", id_pc_plus4_o, 32'h0);
    chk("wr_instr", id_instr_o, mem_word(32'hFFFF_FFFC));
    chk("wr_valid", {31'h0, id_valid_o}, 32'h1);
    chk("wr_next_addr", imem_addr_o, 32'h0);
  endtask

  task automatic test_reset_in_drop();
    imem_ack_i = 1'b1; if_flush_i = 1'b1; branch_target_i = 32'h40;
    step();
    chk("rd_addr40", imem_addr_o, 32'h40);
    imem_ack_i = 1'b0; branch_target_i = 32'h300;
    step();
    if_flush_i = 1'b0;
    chk("rd_drop_addr", imem_addr_o, 32'h40);
    chk("rd_drop_req", {31'h0, imem_req_o}, 32'h1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rd_rst_addr", imem_addr_o, 32'h0);
    chk("rd_rst_req", {31'h0, imem_req_o}, 32'h1);
    chk("rd_rst_valid", {31'h0, id_valid_o}, 32'h0);
    imem_ack_i = 1'b1; imem_rdata_i = mem_word(32'h0);
    pc_write_i = 1'b1; if_id_write_i = 1'b1;
    step();
    chk("rd_post_valid", {31'h0, id_valid_o}, 32'h1);
    chk("rd_post_pc4", id_pc_plus4_o, 32'h4);
    chk("rd_post_instr", id_instr_o, mem_word(32'h0));
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall_buffer();
    test_flush_latency();
    test_flush_with_ack();
    test_wrap();
    test_reset_in_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
